ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester controller that shares one asynchronous single-port RAM (level-sensitive cs/we/oe, tri-state read data) between two clients.
- Arbitrates round-robin, then sequences each access as setup, strobe and recovery phases so the address and write data are stable whenever cs is high.
- Registers read data and returns it to the owning requester.
- Sits between client logic and the RAM instance in the test designs.

Parameters:
ADDR_WIDTH, 8, RAM address width; must match the RAM instance.
DATA_WIDTH, 8, RAM data width; must match the RAM instance.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req0_valid  input  1  requester 0 has a transaction.
req0_ready  output  1  requester 0 transaction accepted this cycle.
req0_we  input  1  1 = write, 0 = read.
req0_addr  input  ADDR_WIDTH  requester 0 address.
req0_wdata  input  DATA_WIDTH  requester 0 write data.
rsp0_valid  output  1  one-cycle completion pulse for requester 0.
rsp0_rdata  output  DATA_WIDTH  read data for requester 0; zero for writes.
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
ram_address  output  ADDR_WIDTH  to RAM address.
ram_data_in  output  DATA_WIDTH  to RAM write data.
ram_data_out  input  DATA_WIDTH  from RAM read data (tri-state net).
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_oe  output  1  RAM output enable.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, while rst_n=0):
  - State is IDLE; all outputs are 0: ram_cs, ram_we, ram_oe, ram_address, ram_data_in, rsp*_valid, rsp*_rdata, busy.
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-operation:
  - Strobes drop immediately, without waiting for a clock edge.
  - The in-flight transaction is discarded; no rsp pulse is issued.
- States: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE, arbitration:
  - reqN_ready is combinational: asserted only in IDLE, and only for the granted requester.
  - Only one requester is selected, so at most one ready is high in any cycle.
  - Grant rule: if exactly one valid is high, grant it. If both are high, grant the requester not equal to last_grant.
  - A handshake occurs when valid && ready.
  - On a handshake: latch we/addr/wdata and the owner id, update last_grant to the owner, go to SETUP.
  - With no valid, stay in IDLE.
- SETUP:
  - ram_address and ram_data_in are driven from the latched request (registered outputs).
  - ram_cs=ram_we=ram_oe=0.
- ACCESS:
  - ram_cs=1.
  - Write: ram_we=1, ram_oe=0.
  - Read: ram_we=0, ram_oe=1.
  - Address and data are unchanged.
  - At the closing clock edge of ACCESS, a read captures ram_data_out into the response register.
- RECOVER:
  - ram_cs=ram_we=ram_oe=0; address and data are still held.
  - rsp_valid of the owner is 1 for this cycle only.
  - rsp_rdata holds the captured read data, or 0 for a write.
  - rsp_rdata keeps its value until the next response to the same requester.
- Latency: handshake at cycle T; strobe at T+2; rsp_valid at T+3; next handshake possible at T+4. Throughput is one access per 4 cycles.
- Invariants:
  - ram_we and ram_oe are never high together.
  - Neither is high unless ram_cs is high.
  - ram_address and ram_data_in never change while ram_cs=1.
- Address and data are passed through unmodified: no arithmetic and no wrap logic. Address 2^ADDR_WIDTH-1 is valid.
- Requests that arrive while busy remain pending (valid held by the client). The client must not drop valid before ready.
- A requester that holds valid continuously with no competition is granted back-to-back, every 4 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately and busy=0. After release, both requesters valid -> req0_ready high first.
- Write then read: req0 writes 0xA5 to 0x3C, then reads 0x3C -> each rsp0_valid pulses once, 3 cycles after its handshake. rsp0_rdata=0x00 after the write and 0xA5 after the read. ram_cs is high for exactly 1 cycle per access.
- Contention: both valid continuously, req0 writing 0x11@0x01 and req1 writing 0x22@0x02 -> grants alternate 0,1,0,1, each handshake 4 cycles apart. A subsequent read of 0x02 by req0 returns 0x22.
- Boundary address: req1 writes 0x7E to 0xFF, then reads 0xFF -> rsp1_rdata=0x7E. Address 0x00 still holds its earlier value.
- Reset during ACCESS: pull rst_n low while ram_cs=1 -> ram_cs/ram_we drop asynchronously and no rsp pulse is issued. After release, normal operation resumes with req0 priority.
- Protocol checker, run on all tests: ram_we&&ram_oe never high; ram_address stable while ram_cs=1; at most one reqN_ready per cycle.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Client-facing request/response channels and the RAM pin bus of ram_arbiter.
// Pure wiring: no logic, no latency.
// Clients hold req*_valid until req*_ready; the arbiter owns all RAM strobes.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // requester 0
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;
    // requester 1
    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;
    // RAM pins
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    // status
    logic                  busy;

    // arbiter side
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_address, ram_data_in, ram_cs, ram_we, ram_oe,
        input  ram_data_out,
        output busy
    );

    // client + RAM side
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_address, ram_data_in, ram_cs, ram_we, ram_oe,
        output ram_data_out,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one asynchronous single-port RAM between two clients.
// Latency: handshake T, strobe T+2, rsp_valid T+3, next handshake T+4 (1 access / 4 cycles).
// Backpressure: ready only in IDLE for the granted client; losers hold valid until granted.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_grant;   // owner of the most recent accepted request
    logic owner;        // owner of the in-flight request
    logic op_we;        // in-flight request is a write
    logic grant0;
    logic grant1;

    // Round-robin pick: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    // State register; reset returns to IDLE at once so strobes fall without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the purely state-decoded outputs (ready, strobes, rsp pulses, busy).
    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.ram_cs     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_oe     = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.busy       = 1'b0;
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                if (grant0 || grant1) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.ram_cs = 1'b1;
                bus.ram_we = op_we;
                bus.ram_oe = !op_we;
                state_nxt  = RECOVER;
            end
            RECOVER: begin
                bus.rsp0_valid = !owner;
                bus.rsp1_valid = owner;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winning request; address/data feed the RAM pins directly so they are
    // settled from SETUP onward and cannot move while cs is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            op_we           <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_data_in <= '0;
        end else if (state == IDLE && (grant0 || grant1)) begin
            last_grant      <= grant1;
            owner           <= grant1;
            op_we           <= grant1 ? bus.req1_we    : bus.req0_we;
            bus.ram_address <= grant1 ? bus.req1_addr  : bus.req0_addr;
            bus.ram_data_in <= grant1 ? bus.req1_wdata : bus.req0_wdata;
        end
    end

    // Capture the response at the closing edge of ACCESS; writes report zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp0_rdata <= '0;
            bus.rsp1_rdata <= '0;
        end else if (state == ACCESS) begin
            if (owner) begin
                bus.rsp1_rdata <= op_we ? '0 : bus.ram_data_out;
            end else begin
                bus.rsp0_rdata <= op_we ? '0 : bus.ram_data_out;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a timeline model.
// Model predicts each access from its handshake cycle (strobe at +2, response at +3).
// Clients hold valid until their modelled grant.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } tx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: writes land while cs&&we at the clock; read bus idles at zero.
    logic [DW-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_data_in;
    end
    assign bus.ram_data_out = (bus.ram_cs && bus.ram_oe) ? ram_mem[bus.ram_address] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus queues (main pushes, driver reads) ----------------
    tx_t q0[$];
    tx_t q1[$];
    int  rd0 = 0, rd1 = 0;
    int  pop0 = 0, pop1 = 0;
    bit  pres0 = 0, pres1 = 0;
    bit  rnd_mode = 0;
    int  flush_cnt = 0, flush_seen = 0;

    // ---------------- reference model state (compare process only) ----------------
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    bit            m_active = 0;
    bit            m_last = 1;
    int            m_hs_cyc = 0;
    bit            m_own = 0;
    tx_t           m_tx;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_rsp [2] = '{default: '0};
    int            hs_cnt [2] = '{0, 0};
    logic [AW-1:0] prev_addr = '0;
    int            cs_cnt = 0;

    // logs of what the DUT did, for the directed literal checks
    int            hs_log_own[$];
    int            hs_log_cyc[$];
    int            rsp_log_own[$];
    int            rsp_log_cyc[$];
    int            rsp_log_dat[$];

    // Client driver: present the head of each queue, advance after its modelled handshake.
    initial begin
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (flush_cnt != flush_seen) begin
                flush_seen = flush_cnt;
                rd0 = q0.size(); rd1 = q1.size();
                pop0 = hs_cnt[0]; pop1 = hs_cnt[1];
                pres0 = 0; pres1 = 0;
            end
            if (hs_cnt[0] != pop0) begin pop0++; rd0++; pres0 = 0; end
            if (hs_cnt[1] != pop1) begin pop1++; rd1++; pres1 = 0; end
            if (!pres0 && rd0 < q0.size() && (!rnd_mode || $urandom_range(0, 1) == 1)) pres0 = 1;
            if (!pres1 && rd1 < q1.size() && (!rnd_mode || $urandom_range(0, 1) == 1)) pres1 = 1;
            bus.req0_valid = pres0;
            if (pres0) begin
                bus.req0_we = q0[rd0].we; bus.req0_addr = q0[rd0].addr; bus.req0_wdata = q0[rd0].wdata;
            end
            bus.req1_valid = pres1;
            if (pres1) begin
                bus.req1_we = q1[rd1].we; bus.req1_addr = q1[rd1].addr; bus.req1_wdata = q1[rd1].wdata;
            end
        end
    end

    // Compare process: timeline model of each access, checked every cycle.
    always @(negedge clk) begin
        bit g0, g1;
        bit e_r0, e_r1, e_cs, e_we, e_oe, e_v0, e_v1;
        int d;
        g0 = 0; g1 = 0;
        e_r0 = 0; e_r1 = 0; e_cs = 0; e_we = 0; e_oe = 0; e_v0 = 0; e_v1 = 0;
        if (!rst_n) begin
            m_active = 0; m_last = 1; m_rsp[0] = '0; m_rsp[1] = '0;
            chk("rst_cs", bus.ram_cs, 0);
            chk("rst_we", bus.ram_we, 0);
            chk("rst_oe", bus.ram_oe, 0);
            chk("rst_addr", bus.ram_address, 0);
            chk("rst_din", bus.ram_data_in, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rsp0_valid", bus.rsp0_valid, 0);
            chk("rst_rsp1_valid", bus.rsp1_valid, 0);
            chk("rst_rsp0_rdata", bus.rsp0_rdata, 0);
            chk("rst_rsp1_rdata", bus.rsp1_rdata, 0);
        end else begin
            d = cyc - m_hs_cyc;
            if (!m_active) begin
                g0 = bus.req0_valid && (!bus.req1_valid || m_last);
                g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
                e_r0 = g0; e_r1 = g1;
            end else if (d == 2) begin
                e_cs = 1; e_we = m_tx.we; e_oe = !m_tx.we;
                if (!m_tx.we) m_rd = ref_mem[m_tx.addr];
            end else if (d == 3) begin
                if (m_own) e_v1 = 1; else e_v0 = 1;
                m_rsp[m_own] = m_tx.we ? '0 : m_rd;
                if (m_tx.we) ref_mem[m_tx.addr] = m_tx.wdata;
            end
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("busy", bus.busy, m_active);
            chk("ram_cs", bus.ram_cs, e_cs);
            chk("ram_we", bus.ram_we, e_we);
            chk("ram_oe", bus.ram_oe, e_oe);
            chk("rsp0_valid", bus.rsp0_valid, e_v0);
            chk("rsp1_valid", bus.rsp1_valid, e_v1);
            chk("rsp0_rdata", bus.rsp0_rdata, m_rsp[0]);
            chk("rsp1_rdata", bus.rsp1_rdata, m_rsp[1]);
            if (m_active) begin
                chk("ram_address", bus.ram_address, m_tx.addr);
                if (m_tx.we) chk("ram_data_in", bus.ram_data_in, m_tx.wdata);
            end
            // protocol invariants
            chk("we_and_oe", bus.ram_we && bus.ram_oe, 0);
            chk("strobe_without_cs", (bus.ram_we || bus.ram_oe) && !bus.ram_cs, 0);
            chk("two_readies", bus.req0_ready && bus.req1_ready, 0);
            if (bus.ram_cs) begin
                chk("addr_stable_cs", bus.ram_address, prev_addr);
                cs_cnt++;
            end
            // DUT activity logs
            if (bus.req0_valid && bus.req0_ready) begin hs_log_own.push_back(0); hs_log_cyc.push_back(cyc); end
            if (bus.req1_valid && bus.req1_ready) begin hs_log_own.push_back(1); hs_log_cyc.push_back(cyc); end
            if (bus.rsp0_valid) begin
                rsp_log_own.push_back(0); rsp_log_cyc.push_back(cyc); rsp_log_dat.push_back(int'(bus.rsp0_rdata));
            end
            if (bus.rsp1_valid) begin
                rsp_log_own.push_back(1); rsp_log_cyc.push_back(cyc); rsp_log_dat.push_back(int'(bus.rsp1_rdata));
            end
            // advance model
            if (m_active && d == 3) begin
                m_active = 0;
            end else if (!m_active && (g0 || g1)) begin
                m_active = 1; m_hs_cyc = cyc; m_own = g1; m_last = g1;
                m_tx.we    = g1 ? bus.req1_we    : bus.req0_we;
                m_tx.addr  = g1 ? bus.req1_addr  : bus.req0_addr;
                m_tx.wdata = g1 ? bus.req1_wdata : bus.req0_wdata;
                hs_cnt[g1]++;
            end
        end
        prev_addr = bus.ram_address;
    end

    function automatic tx_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
        tx_t t;
        t.we = we; t.addr = a; t.wdata = w;
        return t;
    endfunction

    // Wait until every queued request has completed, bounded by a cycle budget.
    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((rd0 < q0.size() || rd1 < q1.size() || pres0 || pres1 || m_active) && n < max_cyc) begin
            @(posedge clk); n++;
        end
        chk("drain_timeout", n >= max_cyc, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int hb, rb, cb;
        bit hit;
        // -------- power-on reset --------
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // -------- contention: both valid, grants alternate starting with req0 --------
        hb = hs_log_own.size();
        q0.push_back(mk(1, 8'h01, 8'h11)); q0.push_back(mk(1, 8'h03, 8'h33));
        q1.push_back(mk(1, 8'h02, 8'h22)); q1.push_back(mk(1, 8'h04, 8'h44));
        drain(100);
        if (hs_log_own.size() - hb == 4) begin
            chk("cont_grant0", hs_log_own[hb],     0);
            chk("cont_grant1", hs_log_own[hb + 1], 1);
            chk("cont_grant2", hs_log_own[hb + 2], 0);
            chk("cont_grant3", hs_log_own[hb + 3], 1);
            for (int i = 1; i < 4; i++)
                chk("cont_spacing", hs_log_cyc[hb + i] - hs_log_cyc[hb + i - 1], 4);
        end else chk("cont_hs_count", hs_log_own.size() - hb, 4);

        // -------- write then read by req0 --------
        rb = rsp_log_own.size(); hb = hs_log_own.size(); cb = cs_cnt;
        q0.push_back(mk(1, 8'h3C, 8'hA5)); q0.push_back(mk(0, 8'h3C, 8'h00));
        drain(100);
        if (rsp_log_own.size() - rb == 2 && hs_log_own.size() - hb == 2) begin
            chk("wr_latency", rsp_log_cyc[rb] - hs_log_cyc[hb], 3);
            chk("rd_latency", rsp_log_cyc[rb + 1] - hs_log_cyc[hb + 1], 3);
            chk("wr_rdata", rsp_log_dat[rb], 8'h00);
            chk("rd_rdata", rsp_log_dat[rb + 1], 8'hA5);
        end else chk("wr_rd_rsp_count", rsp_log_own.size() - rb, 2);
        chk("cs_cycles", cs_cnt - cb, 2);

        // -------- read back a contention write --------
        rb = rsp_log_own.size();
        q0.push_back(mk(0, 8'h02, 8'h00));
        drain(100);
        if (rsp_log_dat.size() - rb == 1) chk("read_0x02", rsp_log_dat[rb], 8'h22);
        else chk("read_0x02_count", rsp_log_dat.size() - rb, 1);

        // -------- boundary address --------
        rb = rsp_log_own.size();
        q1.push_back(mk(1, 8'hFF, 8'h7E)); q1.push_back(mk(0, 8'hFF, 8'h00));
        drain(100);
        q0.push_back(mk(0, 8'h00, 8'h00)); q0.push_back(mk(0, 8'h01, 8'h00));
        drain(100);
        if (rsp_log_dat.size() - rb == 4) begin
            chk("bnd_owner", rsp_log_own[rb + 1], 1);
            chk("bnd_read_ff", rsp_log_dat[rb + 1], 8'h7E);
            chk("bnd_read_00", rsp_log_dat[rb + 2], 8'h00);
            chk("bnd_read_01", rsp_log_dat[rb + 3], 8'h11);
        end else chk("bnd_rsp_count", rsp_log_dat.size() - rb, 4);

        // -------- reset while cs is high --------
        q0.push_back(mk(1, 8'h05, 8'h99));
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #1;
            hit = bus.ram_cs;
        end
        chk("saw_cs_before_reset", hit, 1);
        #1 rst_n = 0;
        flush_cnt++;
        #1;
        chk("async_cs_drop", bus.ram_cs, 0);
        chk("async_we_drop", bus.ram_we, 0);
        chk("async_oe_drop", bus.ram_oe, 0);
        chk("async_busy_drop", bus.busy, 0);
        chk("async_rsp0_drop", bus.rsp0_valid, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        hb = hs_log_own.size();
        q1.push_back(mk(0, 8'h02, 8'h00));
        q0.push_back(mk(0, 8'h05, 8'h00));
        drain(100);
        if (hs_log_own.size() - hb == 2) chk("post_reset_first_grant", hs_log_own[hb], 0);
        else chk("post_reset_hs_count", hs_log_own.size() - hb, 2);

        // -------- randomized traffic --------
        rnd_mode = 1;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                            8'($urandom)));
            q1.push_back(mk(1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                            8'($urandom)));
        end
        drain(6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
